// File: rtl/sram_arb_pkg.sv
// Shared widths, request payload and init-sequencer states for the SRAM arbiter.
package sram_arb_pkg;

  localparam int unsigned SRAM_ADDR_W = 7;
  localparam int unsigned SRAM_DATA_W = 64;
  localparam int unsigned SRAM_DEPTH  = 128;

  typedef struct packed {
    logic                   wen;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } req_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin grant; the pointer remembers the last granted port.
module sram_rr_arb2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last_q;

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

  // Reset to 1 so port 0 wins the first contended cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else if (|grant) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/sram_sp_arbiter.sv
// Two-port round-robin front end for a single-port 1-cycle-latency SRAM macro.
// Optional SRAM_ARB_INIT_EN: post-reset sequencer fills every word with INIT_VALUE.
module sram_sp_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = SRAM_ADDR_W,
  parameter int unsigned DATA_W = SRAM_DATA_W
`ifdef SRAM_ARB_INIT_EN
  ,
  parameter int unsigned        DEPTH      = SRAM_DEPTH,
  parameter logic [DATA_W-1:0]  INIT_VALUE = '0
`endif
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_wen,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        resp_valid,
  input  logic [1:0]        resp_ready,
  output logic [DATA_W-1:0] resp_rdata0,
  output logic [DATA_W-1:0] resp_rdata1,
  output logic              init_done,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  logic [1:0] elig;
  logic [1:0] grant;
  logic [1:0] inflight;
  logic       any_grant;
  logic       init_wr_c;
  req_t       req0;
  req_t       req1;
  req_t       sel;

`ifdef SRAM_ARB_INIT_EN
  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // One init write per cycle; leave INIT after the last word.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    init_wr_c = 1'b0;
    if (state_q == INIT) begin
      init_wr_c = reset_n;
      cnt_d     = cnt_q + ADDR_W'(1);
      if (cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_d = RUN;
      end
    end
  end

  assign init_done = (state_q == RUN);
`else
  assign init_wr_c = 1'b0;
  assign init_done = 1'b1;
`endif

  // Reads also need a free response slot; writes produce no response.
  assign elig[0] = req_valid[0] & init_done & reset_n & ~inflight[0] &
                   (req_wen[0] | ~resp_valid[0] | resp_ready[0]);
  assign elig[1] = req_valid[1] & init_done & reset_n & ~inflight[1] &
                   (req_wen[1] | ~resp_valid[1] | resp_ready[1]);

  sram_rr_arb2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (elig),
    .grant   (grant)
  );

  assign req_ready = grant;
  assign any_grant = |grant;

  assign req0 = '{wen: req_wen[0], addr: SRAM_ADDR_W'(req_addr0), wdata: SRAM_DATA_W'(req_wdata0)};
  assign req1 = '{wen: req_wen[1], addr: SRAM_ADDR_W'(req_addr1), wdata: SRAM_DATA_W'(req_wdata1)};
  assign sel  = grant[1] ? req1 : req0;

  always_comb begin
    sram_ceb = ~any_grant;
    sram_web = ~(any_grant & sel.wen);
    sram_a   = ADDR_W'(sel.addr);
    sram_d   = DATA_W'(sel.wdata);
`ifdef SRAM_ARB_INIT_EN
    if (init_wr_c) begin
      sram_ceb = 1'b0;
      sram_web = 1'b0;
      sram_a   = cnt_q;
      sram_d   = INIT_VALUE;
    end
`else
    if (init_wr_c) begin
      sram_ceb = 1'b0;
    end
`endif
  end

  // Q is only valid the cycle after a read, so capture it exactly then.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      inflight    <= 2'b00;
      resp_valid  <= 2'b00;
      resp_rdata0 <= '0;
      resp_rdata1 <= '0;
    end else begin
      inflight <= grant & ~req_wen;
      if (inflight[0]) begin
        resp_valid[0] <= 1'b1;
        resp_rdata0   <= sram_q;
      end else if (resp_ready[0]) begin
        resp_valid[0] <= 1'b0;
      end
      if (inflight[1]) begin
        resp_valid[1] <= 1'b1;
        resp_rdata1   <= sram_q;
      end else if (resp_ready[1]) begin
        resp_valid[1] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// Directed bench for sram_sp_arbiter with a behavioural 128x64 single-port SRAM.
module tb_sram_sp_arbiter;

  logic        clock;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_wen;
  logic [6:0]  req_addr0, req_addr1;
  logic [63:0] req_wdata0, req_wdata1;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [63:0] resp_rdata0, resp_rdata1;
  logic        init_done;
  logic        sram_ceb, sram_web;
  logic [6:0]  sram_a;
  logic [63:0] sram_d, sram_q;

  int errors = 0;
  int checks = 0;

  logic [63:0] mem [128];

`ifdef SRAM_ARB_INIT_EN
  sram_sp_arbiter #(.INIT_VALUE(64'hDEAD)) u_dut (
`else
  sram_sp_arbiter u_dut (
`endif
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wen     (req_wen),
    .req_addr0   (req_addr0),
    .req_addr1   (req_addr1),
    .req_wdata0  (req_wdata0),
    .req_wdata1  (req_wdata1),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata0 (resp_rdata0),
    .resp_rdata1 (resp_rdata1),
    .init_done   (init_done),
    .sram_ceb    (sram_ceb),
    .sram_web    (sram_web),
    .sram_a      (sram_a),
    .sram_d      (sram_d),
    .sram_q      (sram_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Macro model: Q is garbage on every non-read cycle.
  always @(posedge clock) begin
    if (!sram_ceb && !sram_web) mem[sram_a] <= sram_d;
    if (!sram_ceb && sram_web) sram_q <= mem[sram_a];
    else sram_q <= {$urandom, $urandom};
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 2'b11; req_wen = 2'b00; resp_ready = 2'b00;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    tick(); tick();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", req_ready); end
    checks++; if (sram_ceb !== 1'b1) begin errors++; $display("FAIL reset_ceb got %b exp 1", sram_ceb); end
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid got %b exp 00", resp_valid); end
    checks++; if (resp_rdata0 !== 64'h0) begin errors++; $display("FAIL reset_rdata0 got %h exp 0", resp_rdata0); end
    checks++; if (resp_rdata1 !== 64'h0) begin errors++; $display("FAIL reset_rdata1 got %h exp 0", resp_rdata1); end
`ifndef SRAM_ARB_INIT_EN
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL reset_init_done got %b exp 1", init_done); end
`else
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b exp 0", init_done); end
`endif
    req_valid = 2'b00;
    reset_n = 1'b1;
  endtask

`ifdef SRAM_ARB_INIT_EN
  task automatic test_init();
    int nwr = 0;
    int done_cyc = -1;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (init_done) begin done_cyc = c; break; end
      if (!sram_ceb && !sram_web && sram_a == 7'(c) && sram_d == 64'hDEAD) nwr++;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL init_ready c=%0d got %b exp 00", c, req_ready); end
      @(negedge clock);
    end
    checks++; if (nwr != 128) begin errors++; $display("FAIL init_writes got %0d exp 128", nwr); end
    checks++; if (done_cyc != 128) begin errors++; $display("FAIL init_done_cycle got %0d exp 128", done_cyc); end
    @(negedge clock);
    req_valid = 2'b01; req_wen = 2'b00; req_addr0 = 7'd127;
    tick();
    req_valid = 2'b00;
    tick();
    checks++; if (resp_rdata0 !== 64'hDEAD) begin errors++; $display("FAIL init_readback got %h exp dead", resp_rdata0); end
    resp_ready = 2'b11; tick(); resp_ready = 2'b00;
  endtask
`endif

  task automatic test_single_read();
    req_valid = 2'b01; req_wen = 2'b01; req_addr0 = 7'd3; req_wdata0 = 64'h5A5A;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_ready got %b exp 01", req_ready); end
    checks++; if ({sram_ceb, sram_web} !== 2'b00) begin errors++; $display("FAIL wr_ceb_web got %b exp 00", {sram_ceb, sram_web}); end
    checks++; if (sram_a !== 7'd3 || sram_d !== 64'h5A5A) begin errors++; $display("FAIL wr_addr_data got %h/%h exp 3/5a5a", sram_a, sram_d); end
    tick();
    req_wen = 2'b00;
    #1;
    checks++; if ({req_ready, sram_ceb, sram_web} !== 4'b0101) begin errors++; $display("FAIL rd_issue got %b exp 0101", {req_ready, sram_ceb, sram_web}); end
    tick();
    req_valid = 2'b00;
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL rd_early_valid got %b exp 00", resp_valid); end
    tick();
    checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL rd_valid got %b exp 01", resp_valid); end
    checks++; if (resp_rdata0 !== 64'h5A5A) begin errors++; $display("FAIL rd_data got %h exp 5a5a", resp_rdata0); end
    resp_ready = 2'b01;
    tick();
    resp_ready = 2'b00;
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL rd_drain got %b exp 00", resp_valid); end
  endtask

  task automatic test_contention();
    req_valid = 2'b10; req_wen = 2'b10; req_addr1 = 7'd10; req_wdata1 = 64'h1111_2222;
    tick();
    req_valid = 2'b11; req_wen = 2'b00; req_addr0 = 7'd3; resp_ready = 2'b11;
    for (int i = 0; i < 6; i++) begin
      logic [1:0] exp_g;
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL contend_grant i=%0d got %b exp %b", i, req_ready, exp_g); end
      tick();
    end
    req_valid = 2'b00;
    tick();
    checks++; if (resp_valid !== 2'b10) begin errors++; $display("FAIL contend_valid got %b exp 10", resp_valid); end
    checks++; if (resp_rdata0 !== 64'h5A5A) begin errors++; $display("FAIL contend_rdata0 got %h exp 5a5a", resp_rdata0); end
    checks++; if (resp_rdata1 !== 64'h1111_2222) begin errors++; $display("FAIL contend_rdata1 got %h exp 11112222", resp_rdata1); end
    tick();
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL contend_drain got %b exp 00", resp_valid); end
  endtask

  task automatic test_write_read();
    req_valid = 2'b10; req_wen = 2'b10; req_addr1 = 7'd21; req_wdata1 = 64'hCAFE;
    tick();
    req_wen = 2'b00;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL wr_rd_ready got %b exp 10", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    checks++; if (resp_valid !== 2'b10 || resp_rdata1 !== 64'hCAFE) begin errors++; $display("FAIL wr_rd_data got %b/%h exp 10/cafe", resp_valid, resp_rdata1); end
    tick();
  endtask

  task automatic test_backpressure();
    resp_ready = 2'b00;
    req_valid = 2'b10; req_wen = 2'b00; req_addr1 = 7'd10;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_first got %b exp 10", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    checks++; if (resp_valid !== 2'b10 || resp_rdata1 !== 64'h1111_2222) begin errors++; $display("FAIL bp_resp got %b/%h exp 10/11112222", resp_valid, resp_rdata1); end
    resp_ready = 2'b01;
    for (int i = 0; i < 5; i++) begin
      logic [1:0] exp_g;
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      req_valid = 2'b11;
      req_wen = (i % 2 == 0) ? 2'b00 : 2'b10;
      req_addr1 = (i % 2 == 0) ? 7'd10 : 7'd20;
      req_wdata1 = 64'hABCD_0000 + 64'(i);
      #1;
      checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL bp_grant i=%0d got %b exp %b", i, req_ready, exp_g); end
      checks++; if (resp_valid[1] !== 1'b1 || resp_rdata1 !== 64'h1111_2222) begin errors++; $display("FAIL bp_hold i=%0d got %b/%h exp 1/11112222", i, resp_valid[1], resp_rdata1); end
      tick();
    end
    req_valid = 2'b00; resp_ready = 2'b11;
    tick();
    checks++; if (resp_valid !== 2'b01 || resp_rdata0 !== 64'h5A5A) begin errors++; $display("FAIL bp_release got %b/%h exp 01/5a5a", resp_valid, resp_rdata0); end
    tick();
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL bp_drain got %b exp 00", resp_valid); end
    req_valid = 2'b10; req_wen = 2'b00; req_addr1 = 7'd20;
    tick();
    req_valid = 2'b00;
    tick();
    checks++; if (resp_rdata1 !== 64'hABCD_0003) begin errors++; $display("FAIL bp_write_landed got %h exp abcd0003", resp_rdata1); end
    tick();
  endtask

  task automatic test_idle();
    req_valid = 2'b00; resp_ready = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (sram_ceb !== 1'b1 || resp_valid !== 2'b00) begin errors++; $display("FAIL idle_quiet i=%0d got ceb=%b valid=%b exp 1/00", i, sram_ceb, resp_valid); end
      checks++; if (resp_rdata0 !== 64'h5A5A || resp_rdata1 !== 64'hABCD_0003) begin errors++; $display("FAIL idle_hold i=%0d got %h/%h exp 5a5a/abcd0003", i, resp_rdata0, resp_rdata1); end
    end
  endtask

  task automatic test_reset_mid_read();
    resp_ready = 2'b11;
    req_valid = 2'b01; req_wen = 2'b00; req_addr0 = 7'd3;
    tick();
    req_valid = 2'b00; reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++; if (resp_valid !== 2'b00 || resp_rdata0 !== 64'h0) begin errors++; $display("FAIL midrst_after got %b/%h exp 00/0", resp_valid, resp_rdata0); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL midrst_stale i=%0d got %b exp 00", i, resp_valid); end
    end
  endtask

  initial begin
    test_reset();
`ifdef SRAM_ARB_INIT_EN
    test_init();
`endif
    test_single_read();
    test_contention();
    test_write_read();
    test_backpressure();
    test_idle();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
